mic_adc_reader: RTL and testbench
=================================

// Module: mic_adc_reader
// PURPOSE
// - SPI master for the Pmod MIC3 ADC (ADCS7476). Produces the 12-bit MIC_IN sample bus consumed by volume_lvl and the display/LED tasks.
// - Periodically frames a 16-SCLK conversion (4 leading zeros + 12 data bits, MSB first) and publishes each sample with a 1-cycle valid strobe.
// PARAMETERS
// - CLK_DIV        25    basys_clock cycles per SCLK half-period (25 -> 2 MHz SCLK at 100 MHz); legal range >= 2
// - SAMPLE_PERIOD  5000  basys_clock cycles between conversion starts (20 kHz); must be >= 34*CLK_DIV
// PORTS
// - basys_clock   in   1   system clock, 100 MHz
// - reset_n       in   1   asynchronous, active-low reset
// - enable        in   1   high: conversions are launched; low: no new conversion starts
// - mic_sdata     in   1   ADC serial data (MISO)
// - mic_cs        out  1   ADC chip select, active low
// - mic_sclk      out  1   ADC serial clock, idles high
// - MIC_IN        out  12  last completed sample, unsigned
// - sample_valid  out  1   1-cycle pulse when MIC_IN updates
// - frame_err     out  1   leading-zero check flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: mic_cs=1, mic_sclk=1, MIC_IN=0, sample_valid=0, frame_err=0. All counters are 0; FSM is in IDLE.
// - Reset asserted mid-conversion: mic_cs=1 and mic_sclk=1 immediately (asynchronous). The partial sample is discarded and MIC_IN keeps its reset value 0.
// - Period counter pcnt runs freely 0..SAMPLE_PERIOD-1 and wraps. It is not gated by enable.
// - FSM states: IDLE -> SHIFT -> HOLD -> IDLE.
// - IDLE: when pcnt==0 and enable==1, drive mic_cs low and go to SHIFT at cycle t0. When pcnt==0 and enable==0, skip this slot.
// - SHIFT: mic_sclk falls at t0+CLK_DIV*(2i+1) and rises at t0+CLK_DIV*(2i+2), for i=0..15.
// - Sampling: mic_sdata is registered once (sdata_q). sdata_q is shifted into a 16-bit shift register, LSB-in, on each cycle in which mic_sclk goes 0->1.
// - After the 16th rising edge at t0+32*CLK_DIV, go to HOLD. mic_sclk stays high.
// - HOLD: at t0+33*CLK_DIV, mic_cs goes to 1 and MIC_IN <= shift[11:0]. sample_valid=1 for that cycle only. Return to IDLE.
// - Latency: MIC_IN updates exactly 33*CLK_DIV cycles after the mic_cs falling edge.
// - Max one conversion per SAMPLE_PERIOD. A pcnt==0 event while in SHIFT or HOLD is impossible given the parameter constraint; do not queue it.
// - enable deasserted mid-conversion: the current conversion completes normally, including the valid pulse.
// - MIC_IN is held between samples. sample_valid is never high on two consecutive cycles.
// CONFIGURATION
// - MIC_FRAME_CHECK_EN defined: at the HOLD cycle, frame_err <= |shift[15:12]. MIC_IN still updates. frame_err holds until the next completed conversion.
// - MIC_FRAME_CHECK_EN undefined: no check logic; frame_err is tied to 0.
// TESTING (CLK_DIV=2, SAMPLE_PERIOD=100 unless stated)
// - Reset release, enable=1 -> mic_cs falls at pcnt==0. Exactly 16 SCLK low pulses, each 2 cycles. mic_cs rises 66 cycles after falling. Next mic_cs fall comes 100 cycles after the previous one.
// - ADC model drives 16'h0ABC on SCLK falling edges -> MIC_IN=12'hABC with a single-cycle sample_valid at cs rise. Back-to-back frames 0x0FFF then 0x0000 -> MIC_IN=0xFFF, then 0x000.
// - enable=0 across a pcnt==0 slot -> mic_cs stays 1 and no sample_valid. Drop enable at SCLK edge 5 -> that frame still completes with a valid pulse.
// - Assert reset_n low at SCLK edge 8 -> mic_cs=1, mic_sclk=1, MIC_IN=0, sample_valid=0 within the same cycle. After release, a full clean frame is captured.
// - MIC_FRAME_CHECK_EN defined, ADC drives 16'h8123 -> MIC_IN=12'h123 and frame_err=1. A following frame 16'h0123 -> frame_err=0.
// - CLK_DIV=25, SAMPLE_PERIOD=5000 -> SCLK measures 2 MHz, sample_valid rate is 20 kHz, and mic_cs low time is 825 cycles.

Source files
------------

// File: rtl/mic_adc_reader.sv
// SPI master for the Pmod MIC3 (ADCS7476): frames 16-SCLK conversions every
// SAMPLE_PERIOD cycles and publishes the 12-bit sample. Optional: MIC_FRAME_CHECK_EN.
//
// state | meaning
// IDLE  | mic_cs high, waiting for pcnt==0 with enable set
// SHIFT | mic_cs low, generating 16 SCLK periods and shifting in data
// HOLD  | last rising edge done, wait one half-period then publish the sample
module mic_adc_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic        basys_clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mic_sdata,
  output logic        mic_cs,
  output logic        mic_sclk,
  output logic [11:0] MIC_IN,
  output logic        sample_valid,
  output logic        frame_err
);

  localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] HALF_LD  = DW'(CLK_DIV - 1);

`ifdef MIC_FRAME_CHECK_EN
  localparam int SW = 16;
`else
  // Without the check the leading zeros just fall off the top of the register.
  localparam int SW = 12;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   pcnt;
  logic [DW-1:0]   hcnt;
  logic [4:0]      hnum;
  logic [SW-1:0]   shift;
  logic            sdata_q;

  always_ff @(posedge basys_clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (pcnt == PCNT_MAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge basys_clock or negedge reset_n) begin
    if (!reset_n) begin
      sdata_q <= 1'b0;
    end else begin
      sdata_q <= mic_sdata;
    end
  end

  always_ff @(posedge basys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hcnt         <= '0;
      hnum         <= '0;
      shift        <= '0;
      mic_cs       <= 1'b1;
      mic_sclk     <= 1'b1;
      MIC_IN       <= '0;
      sample_valid <= 1'b0;
`ifdef MIC_FRAME_CHECK_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pcnt == '0 && enable) begin
            mic_cs <= 1'b0;
            hcnt   <= HALF_LD;
            hnum   <= '0;
            shift  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (hcnt == '0) begin
            hcnt     <= HALF_LD;
            mic_sclk <= ~mic_sclk;
            // Capture on the cycle the SCLK register goes 0->1.
            if (!mic_sclk) begin
              shift <= {shift[SW-2:0], sdata_q};
            end
            if (hnum == 5'd31) begin
              state <= HOLD;
            end else begin
              hnum <= hnum + 1'b1;
            end
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        HOLD: begin
          if (hcnt == '0) begin
            mic_cs       <= 1'b1;
            MIC_IN       <= shift[11:0];
            sample_valid <= 1'b1;
`ifdef MIC_FRAME_CHECK_EN
            frame_err    <= |shift[15:12];
`endif
            state        <= IDLE;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          mic_cs   <= 1'b1;
          mic_sclk <= 1'b1;
        end
      endcase
    end
  end

`ifndef MIC_FRAME_CHECK_EN
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_mic_adc_reader.sv
// Directed bench for mic_adc_reader with CLK_DIV=2, SAMPLE_PERIOD=100 and a
// behavioural ADCS7476 that shifts a 16-bit word out on SCLK falling edges.
module tb_mic_adc_reader;

  logic        basys_clock = 1'b0;
  logic        reset_n     = 1'b0;
  logic        enable      = 1'b1;
  logic        mic_sdata   = 1'b0;
  logic        mic_cs;
  logic        mic_sclk;
  logic [11:0] MIC_IN;
  logic        sample_valid;
  logic        frame_err;

  mic_adc_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) dut (
    .basys_clock (basys_clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .mic_sdata   (mic_sdata),
    .mic_cs      (mic_cs),
    .mic_sclk    (mic_sclk),
    .MIC_IN      (MIC_IN),
    .sample_valid(sample_valid),
    .frame_err   (frame_err)
  );

  always #5 basys_clock = ~basys_clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model
  logic [15:0] next_word = 16'h0000;
  logic [15:0] tx_word   = 16'h0000;
  int          bit_idx   = 15;

  always @(negedge mic_cs) begin
    tx_word = next_word;
    bit_idx = 15;
  end

  always @(negedge mic_sclk) begin
    if (!mic_cs && bit_idx >= 0) begin
      mic_sdata = tx_word[bit_idx];
      bit_idx--;
    end
  end

  // Monitor, sampled on the falling clock edge
  int   cyc = 0;
  int   fall_cyc = 0, prev_fall_cyc = 0, rise_cyc = 0, valid_cyc = 0;
  int   fall_count = 0, valid_count = 0;
  int   sclk_falls = 0, sclk_bad = 0, low_run = 0;
  int   double_valid = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;

  always @(negedge basys_clock) begin
    cyc++;
    if (prev_cs && !mic_cs) begin
      prev_fall_cyc = fall_cyc;
      fall_cyc      = cyc;
      fall_count++;
      sclk_falls    = 0;
      sclk_bad      = 0;
    end
    if (!prev_cs && mic_cs) rise_cyc = cyc;
    if (prev_sclk && !mic_sclk) sclk_falls++;
    if (!mic_sclk) low_run++;
    if (!prev_sclk && mic_sclk) begin
      if (low_run != 2) sclk_bad++;
      low_run = 0;
    end
    if (sample_valid) begin
      valid_count++;
      valid_cyc = cyc;
      if (prev_valid) double_valid++;
    end
    prev_cs    = mic_cs;
    prev_sclk  = mic_sclk;
    prev_valid = sample_valid;
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(negedge basys_clock);
      #1;
      n++;
    end while (!sample_valid && n < 300);
    if (!sample_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    do begin
      @(negedge basys_clock);
      #1;
      n++;
    end while (!(sclk_falls >= target && !mic_cs) && n < 300);
    if (n >= 300) check("falls_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge basys_clock);
    #1;
  endtask

  int vc_snap, fc_snap;

  initial begin
    idle_cycles(3);
    check("rst_cs",    32'(mic_cs),       32'd1);
    check("rst_sclk",  32'(mic_sclk),     32'd1);
    check("rst_mic",   32'(MIC_IN),       32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_ferr",  32'(frame_err),    32'd0);

    // Frame 1: 0x0ABC
    next_word = 16'h0ABC;
    @(negedge basys_clock);
    reset_n = 1'b1;
    wait_valid("f1");
    check("f1_mic",     32'(MIC_IN), 32'h0ABC);
    check("f1_falls",   32'(sclk_falls), 32'd16);
    check("f1_lowlen",  32'(sclk_bad), 32'd0);
    check("f1_cs_low",  32'(rise_cyc - fall_cyc), 32'd66);
    check("f1_v_at_cs", 32'(valid_cyc - rise_cyc), 32'd0);
    check("f1_ferr",    32'(frame_err), 32'd0);
    idle_cycles(1);
    check("f1_pulse1",  32'(sample_valid), 32'd0);
    check("f1_hold",    32'(MIC_IN), 32'h0ABC);

    // Back-to-back frames
    next_word = 16'h0FFF;
    wait_valid("f2");
    check("f2_mic",    32'(MIC_IN), 32'h0FFF);
    check("f2_period", 32'(fall_cyc - prev_fall_cyc), 32'd100);
    next_word = 16'h0000;
    wait_valid("f3");
    check("f3_mic",    32'(MIC_IN), 32'h0000);
    check("f3_period", 32'(fall_cyc - prev_fall_cyc), 32'd100);

    // Skip a slot with enable low
    enable  = 1'b0;
    vc_snap = valid_count;
    fc_snap = fall_count;
    idle_cycles(110);
    check("skip_cs",    32'(fall_count - fc_snap), 32'd0);
    check("skip_valid", 32'(valid_count - vc_snap), 32'd0);
    check("skip_mic",   32'(MIC_IN), 32'h0000);

    // Drop enable at SCLK edge 5: frame still completes
    next_word = 16'h0123;
    enable = 1'b1;
    wait_falls(5);
    enable = 1'b0;
    wait_valid("f4");
    check("f4_mic",   32'(MIC_IN), 32'h0123);
    check("f4_falls", 32'(sclk_falls), 32'd16);
    enable = 1'b1;

    // Reset at SCLK edge 8
    next_word = 16'h0555;
    wait_falls(8);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs",    32'(mic_cs), 32'd1);
    check("mid_rst_sclk",  32'(mic_sclk), 32'd1);
    check("mid_rst_mic",   32'(MIC_IN), 32'd0);
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    idle_cycles(3);
    next_word = 16'h0A5A;
    @(negedge basys_clock);
    reset_n = 1'b1;
    wait_valid("f5");
    check("f5_mic",    32'(MIC_IN), 32'h0A5A);
    check("f5_falls",  32'(sclk_falls), 32'd16);
    check("f5_lowlen", 32'(sclk_bad), 32'd0);
    check("f5_cs_low", 32'(rise_cyc - fall_cyc), 32'd66);

    // Leading-zero check
    next_word = 16'h8123;
    wait_valid("f6");
    check("f6_mic", 32'(MIC_IN), 32'h0123);
`ifdef MIC_FRAME_CHECK_EN
    check("f6_ferr", 32'(frame_err), 32'd1);
    next_word = 16'h0123;
    wait_valid("f7");
    check("f7_mic",  32'(MIC_IN), 32'h0123);
    check("f7_ferr", 32'(frame_err), 32'd0);
`else
    check("f6_ferr", 32'(frame_err), 32'd0);
`endif

    idle_cycles(2);
    check("double_valid", 32'(double_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
